// File: rtl/registrador_de_flags_if.sv
// Flag register bus: ALU result/flags and control-unit handshake on one side,
// registered flags and exception capture on the other.
interface registrador_de_flags_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
);
  // ALU / detector / control-unit inputs
  logic                   Enable;
  logic [DATA_WIDTH-1:0]  Data;
  logic                   Seletion_Sum_Sub;
  logic                   Overflow;
  logic                   Zero;
  logic                   Clear_Sticky;
  logic                   Exception_Ack;

  // Registered status and exception outputs
  logic                   Zero_Reg;
  logic                   Overflow_Reg;
  logic                   Negative_Reg;
  logic                   Sticky_Overflow;
  logic                   Exception_Req;
  logic [DATA_WIDTH-1:0]  Exception_Data;
  logic                   Exception_Op;
  logic                   Exception_Lost;
  logic [COUNT_WIDTH-1:0] Overflow_Count;

  // Upstream/control side
  modport master (
    output Enable, Data, Seletion_Sum_Sub, Overflow, Zero, Clear_Sticky, Exception_Ack,
    input  Zero_Reg, Overflow_Reg, Negative_Reg, Sticky_Overflow, Exception_Req,
           Exception_Data, Exception_Op, Exception_Lost, Overflow_Count
  );

  // Flag register side
  modport slave (
    input  Enable, Data, Seletion_Sum_Sub, Overflow, Zero, Clear_Sticky, Exception_Ack,
    output Zero_Reg, Overflow_Reg, Negative_Reg, Sticky_Overflow, Exception_Req,
           Exception_Data, Exception_Op, Exception_Lost, Overflow_Count
  );
endinterface

// File: rtl/registrador_de_flags.sv
// Status/flag register with overflow exception capture and a four-phase
// request/acknowledge handshake towards the control unit.
module registrador_de_flags #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  registrador_de_flags_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_e                 state_q, state_d;
  logic                   zero_q, zero_d;
  logic                   ovf_q, ovf_d;
  logic                   neg_q, neg_d;
  logic                   sticky_q, sticky_d;
  logic                   lost_q, lost_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0]  exc_data_q, exc_data_d;
  logic                   exc_op_q, exc_op_d;
  logic                   capture;
  logic                   ovf_event;

  // An overflow only counts when the detector's flags are valid.
  assign ovf_event = bus.Enable & bus.Overflow;

  // Handshake FSM next state; capture only happens when leaving IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ovf_event) begin
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.Exception_Ack) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!bus.Exception_Ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag, sticky, lost-exception, counter and capture next-state logic.
  always_comb begin
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    sticky_d   = sticky_q;
    lost_d     = lost_q;
    count_d    = count_q;
    exc_data_d = exc_data_q;
    exc_op_d   = exc_op_q;

    if (bus.Enable) begin
      zero_d = bus.Zero;
      ovf_d  = bus.Overflow;
      neg_d  = bus.Data[DATA_WIDTH-1];
    end

    // Clear first so a coincident overflow wins.
    if (bus.Clear_Sticky) begin
      sticky_d = 1'b0;
      lost_d   = 1'b0;
    end

    if (ovf_event) begin
      sticky_d = 1'b1;
      if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
      // Outstanding exception (REQ or WAIT_REL): this overflow cannot be reported.
      if (state_q != IDLE) lost_d = 1'b1;
    end

    if (capture) begin
      exc_data_d = bus.Data;
      exc_op_d   = bus.Seletion_Sum_Sub;
    end
  end

  // State register; synchronous reset clears every output-visible register.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their _d values from the same edge, independent of statement order.
    if (Reset) begin
      // NOTE: the capture registers are reset too, because every output
      // must read 0 after reset, not just the control state.
      state_q    <= IDLE;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      sticky_q   <= 1'b0;
      lost_q     <= 1'b0;
      count_q    <= '0;
      exc_data_q <= '0;
      exc_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      neg_q      <= neg_d;
      sticky_q   <= sticky_d;
      lost_q     <= lost_d;
      count_q    <= count_d;
      exc_data_q <= exc_data_d;
      exc_op_q   <= exc_op_d;
    end
  end

  assign bus.Zero_Reg        = zero_q;
  assign bus.Overflow_Reg    = ovf_q;
  assign bus.Negative_Reg    = neg_q;
  assign bus.Sticky_Overflow = sticky_q;
  assign bus.Exception_Req   = (state_q == REQ);
  assign bus.Exception_Data  = exc_data_q;
  assign bus.Exception_Op    = exc_op_q;
  assign bus.Exception_Lost  = lost_q;
  assign bus.Overflow_Count  = count_q;

endmodule
